// File: rtl/game_flow_ctrl.sv
// Game sequencer: menu -> intro animation -> play -> death/win/lose -> end screen.
// Drives the intro block's reset/enable, tracks lives and selects the screen.
module game_flow_ctrl #(
   parameter int unsigned LIVES        = 3,
   parameter int unsigned RST_PULSE    = 4,
   parameter int unsigned ANIM_TIMEOUT = 650_000_000,
   parameter int unsigned DEATH_HOLD   = 65_000_000,
   parameter int unsigned END_HOLD     = 130_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_btn,
   input  logic       animation,
   input  logic       player_hit,
   input  logic       player_win,
   output logic       anim_rst,
   output logic       game_en,
   output logic       play_en,
   output logic [1:0] lives,
   output logic [1:0] screen,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      ST_MENU, ST_ANIM_RST, ST_ANIM, ST_PLAY, ST_DEATH, ST_WIN, ST_LOSE
   } state_e;

   localparam logic [31:0] RST_LAST   = 32'(RST_PULSE - 1);
   localparam logic [31:0] ANIM_LAST  = 32'(ANIM_TIMEOUT - 1);
   localparam logic [31:0] DEATH_LAST = 32'(DEATH_HOLD - 1);
   localparam logic [31:0] END_LAST   = 32'(END_HOLD - 1);
   localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  lives_q, lives_d;
   logic        start_q;
   logic        anim_rst_q, anim_rst_d;
   logic        game_en_q, game_en_d;
   logic        play_en_q, play_en_d;
   logic [1:0]  screen_q, screen_d;
   logic        start_rise;

   assign start_rise = start_btn & ~start_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_MENU;
         cnt_q      <= '0;
         lives_q    <= '0;
         start_q    <= 1'b0;
         anim_rst_q <= 1'b0;
         game_en_q  <= 1'b0;
         play_en_q  <= 1'b0;
         screen_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lives_q    <= lives_d;
         start_q    <= start_btn;
         anim_rst_q <= anim_rst_d;
         game_en_q  <= game_en_d;
         play_en_q  <= play_en_d;
         screen_q   <= screen_d;
      end
   end

   // Output flops decode the current state, so they trail state_q by one cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 32'd1;
      lives_d    = lives_q;
      anim_rst_d = 1'b0;
      game_en_d  = 1'b0;
      play_en_d  = 1'b0;
      screen_d   = 2'd1;
      case (state_q)
         ST_MENU: begin
            screen_d = 2'd0;
            cnt_d    = '0;
            if (start_rise) begin
               lives_d = LIVES_INIT;
               state_d = ST_ANIM_RST;
            end
         end
         ST_ANIM_RST: begin
            anim_rst_d = 1'b1;
            if (cnt_q == RST_LAST) begin
               cnt_d   = '0;
               state_d = ST_ANIM;
            end
         end
         ST_ANIM: begin
            game_en_d = 1'b1;
            if (!animation || cnt_q == ANIM_LAST) begin
               cnt_d   = '0;
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            game_en_d = 1'b1;
            play_en_d = 1'b1;
            cnt_d     = '0;
            if (player_win) begin
               state_d = ST_WIN;
            end else if (player_hit) begin
               if (lives_q <= 2'd1) begin
                  lives_d = '0;
                  state_d = ST_LOSE;
               end else begin
                  lives_d = lives_q - 2'd1;
                  state_d = ST_DEATH;
               end
            end
         end
         ST_DEATH: begin
            if (cnt_q == DEATH_LAST) begin
               cnt_d   = '0;
               state_d = ST_ANIM_RST;
            end
         end
         ST_WIN, ST_LOSE: begin
            screen_d = (state_q == ST_WIN) ? 2'd2 : 2'd3;
            // Saturate so the screen stays accept-ready indefinitely.
            if (cnt_q == END_LAST) begin
               cnt_d = cnt_q;
               if (start_rise) begin
                  cnt_d   = '0;
                  state_d = ST_MENU;
               end
            end
         end
         default: begin
            state_d  = ST_MENU;
            cnt_d    = '0;
            screen_d = 2'd0;
         end
      endcase
   end

   assign anim_rst  = anim_rst_q;
   assign game_en   = game_en_q;
   assign play_en   = play_en_q;
   assign screen    = screen_q;
   assign lives     = lives_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with shortened hold/timeout parameters.
module tb_game_flow_ctrl;

   logic       clk = 1'b0;
   logic       rst, start_btn, animation, player_hit, player_win;
   logic       anim_rst, game_en, play_en;
   logic [1:0] lives, screen;
   logic [2:0] state_dbg;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, n_ar = 0, n_ent = 0;
   logic [2:0] prev_st = 3'd0;

   game_flow_ctrl #(
      .LIVES(3), .RST_PULSE(4), .ANIM_TIMEOUT(1000), .DEATH_HOLD(10), .END_HOLD(20)
   ) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn), .animation(animation),
      .player_hit(player_hit), .player_win(player_win), .anim_rst(anim_rst),
      .game_en(game_en), .play_en(play_en), .lives(lives), .screen(screen),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one cycle; sample on the falling edge and keep running tallies.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (anim_rst) n_ar++;
      if (state_dbg == 3'd1 && prev_st != 3'd1) n_ent++;
      prev_st = state_dbg;
   endtask

   task automatic wait_state(input logic [2:0] target, input int bound, input string tag);
      int n = 0;
      while (state_dbg != target && n < bound) begin
         tick();
         n++;
      end
      chk(tag, state_dbg, target);
   endtask

   task automatic replay_to_play();
      animation = 1'b1;
      wait_state(3'd2, 50, "reach_anim");
      animation = 1'b0;
      wait_state(3'd3, 10, "reach_play");
   endtask

   task automatic hit();
      player_hit = 1'b1;
      tick();
      player_hit = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic press_start();
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
   endtask

   initial begin
      int d, t0;
      rst = 1'b1; start_btn = 1'b0; animation = 1'b1; player_hit = 1'b0; player_win = 1'b0;
      repeat (3) tick();
      chk("rst_state", state_dbg, 0);
      chk("rst_lives", lives, 0);
      chk("rst_anim_rst", anim_rst, 0);
      rst = 1'b0;

      // Idle in menu
      repeat (50) tick();
      chk("idle_state", state_dbg, 0);
      chk("idle_screen", screen, 0);
      chk("idle_anim_rst", anim_rst, 0);
      chk("idle_game_en", game_en, 0);

      // Held start: one rise, 4-cycle anim_rst pulse
      n_ar = 0; n_ent = 0;
      start_btn = 1'b1;
      repeat (30) tick();
      chk("start_anim_rst_len", n_ar, 4);
      chk("start_one_entry", n_ent, 1);
      chk("start_state", state_dbg, 2);
      chk("start_game_en", game_en, 1);
      chk("start_lives", lives, 3);
      chk("start_screen", screen, 1);
      chk("start_play_en", play_en, 0);
      start_btn = 1'b0;
      repeat (70) tick();
      animation = 1'b0;
      wait_state(3'd3, 10, "enter_play");
      chk("play_en_lag", play_en, 0);
      tick();
      chk("play_en_on", play_en, 1);

      // First death with detailed timing
      hit();
      chk("hit1_lives", lives, 2);
      chk("hit1_state", state_dbg, 4);
      animation = 1'b1;
      tick();
      chk("death_play_en", play_en, 0);
      chk("death_game_en", game_en, 0);
      d = 1;
      while (state_dbg == 3'd4 && d < 50) begin
         d++;
         tick();
      end
      chk("death_hold_len", d, 10);
      chk("death_to_anim_rst", state_dbg, 1);
      n_ar = 0;
      wait_state(3'd2, 20, "death_replay_anim");
      chk("death_anim_rst_len", n_ar, 4);
      chk("death_lives_kept", lives, 2);
      animation = 1'b0;
      wait_state(3'd3, 10, "death_replay_play");

      hit();
      chk("hit2_lives", lives, 1);
      replay_to_play();
      hit();
      chk("hit3_lives", lives, 0);
      chk("hit3_state", state_dbg, 6);
      tick();
      chk("lose_screen", screen, 3);
      chk("lose_play_en", play_en, 0);

      // End hold: early start ignored, late start accepted
      repeat (3) tick();
      press_start();
      chk("end_early_ignored", state_dbg, 6);
      repeat (19) tick();
      press_start();
      chk("end_late_state", state_dbg, 0);
      tick();
      chk("end_late_screen", screen, 0);

      // Simultaneous win and hit with one life left
      do_reset();
      press_start();
      replay_to_play();
      hit();
      replay_to_play();
      hit();
      replay_to_play();
      chk("sim_lives_before", lives, 1);
      player_hit = 1'b1; player_win = 1'b1;
      tick();
      player_hit = 1'b0; player_win = 1'b0;
      chk("sim_state", state_dbg, 5);
      chk("sim_lives", lives, 1);
      tick();
      chk("sim_screen", screen, 2);
      hit();
      chk("win_hit_ignored", lives, 1);

      // Watchdog: animation never falls
      do_reset();
      press_start();
      animation = 1'b1;
      wait_state(3'd2, 20, "wd_anim");
      t0 = cyc;
      wait_state(3'd3, 1100, "wd_play");
      chk("wd_latency", cyc - t0, 1000);
      tick();
      chk("wd_play_en", play_en, 1);

      // Reset mid-play
      do_reset();
      chk("mid_rst_state", state_dbg, 0);
      chk("mid_rst_play_en", play_en, 0);
      chk("mid_rst_game_en", game_en, 0);
      chk("mid_rst_lives", lives, 0);
      chk("mid_rst_screen", screen, 0);
      chk("mid_rst_anim_rst", anim_rst, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
